// File: rtl/ppl_pkg.sv
// Shared types and constants for the pipeline-register chain.
// Latency: n/a (declarations only).
// Backpressure: n/a; the stage_ctl_t select encodes hold/bubble/kill for each stage.
package ppl_pkg;

   // Stage indices of the classic five-stage core.
   localparam int IFID = 0;
   localparam int IDEX = 1;
   localparam int EXME = 2;
   localparam int MEWB = 3;

   // Instruction NOP encoding (low 32 bits of a bubble payload).
   localparam logic [31:0] NOP = 32'h0000_0000;

   // Per-stage next-state select.
   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      HOLD   = 2'd1,
      BUBBLE = 2'd2,
      KILL   = 2'd3
   } stage_ctl_t;

endpackage

// File: rtl/ppl_stage.sv
// One pipeline register: payload plus valid, next state picked by a LOAD/HOLD/BUBBLE/KILL select.
// Latency: 1 cycle from d to q.
// Backpressure: HOLD keeps contents; BUBBLE and KILL load NOP_VAL with valid cleared.
module ppl_stage
   import ppl_pkg::*;
#(
   parameter int               WIDTH   = 96,
   parameter logic [WIDTH-1:0] NOP_VAL = '0
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [1:0]       ctl,
   input  logic [WIDTH-1:0] d,
   input  logic             vld_d,
   output logic [WIDTH-1:0] q,
   output logic             vld_q
);

   // Register update: reset and drained states both carry the NOP payload.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         q     <= NOP_VAL;
         vld_q <= 1'b0;
      end else begin
         case (stage_ctl_t'(ctl))
            LOAD: begin
               q     <= d;
               vld_q <= vld_d;
            end
            BUBBLE, KILL: begin
               q     <= NOP_VAL;
               vld_q <= 1'b0;
            end
            default: ; // HOLD keeps contents
         endcase
      end
   end

endmodule

// File: rtl/ppl_stage_chain.sv
// NSTAGE pipeline registers with stall cascade, bubble insertion below held stages, and per-stage kill.
// Latency: 1 cycle per stage; occupancy is registered alongside the valid bits.
// Backpressure: a stall holds its stage and everything upstream; ppEN=0 freezes the chain. PPL_PERF_EN adds counters.
module ppl_stage_chain
   import ppl_pkg::*;
#(
   parameter int                NSTAGE  = 4,
   parameter int                WIDTH   = 96,
   parameter logic [WIDTH-1:0]  NOP_VAL = '0
) (
   input  logic                         CLK,
   input  logic                         nRST,
   input  logic                         ppEN,
   input  logic [NSTAGE*WIDTH-1:0]      stage_d,
   input  logic [NSTAGE-1:0]            stage_vld_d,
   input  logic [NSTAGE-1:0]            stall,
   input  logic [NSTAGE-1:0]            kill,
   output logic [NSTAGE*WIDTH-1:0]      stage_q,
   output logic [NSTAGE-1:0]            stage_vld_q,
   output logic [NSTAGE-1:0]            hold_q,
   output logic [$clog2(NSTAGE+1)-1:0]  occupancy
`ifdef PPL_PERF_EN
   ,
   output logic [31:0]                  bubble_cnt,
   output logic [31:0]                  stall_cnt
`endif
);

   localparam int OW = $clog2(NSTAGE+1);

   logic [NSTAGE-1:0] hold;
   logic [NSTAGE-1:0] above;
   logic [NSTAGE-1:0] bub;
   logic [NSTAGE-1:0] vld_nxt;
   logic [OW-1:0]     occ_nxt;
   logic [1:0]        ctl [NSTAGE];

   // Stall cascade: a held stage forces every upstream stage to hold too.
   always_comb begin
      hold[NSTAGE-1] = stall[NSTAGE-1];
      for (int i = NSTAGE-2; i >= 0; i--) begin
         hold[i] = stall[i] | hold[i+1];
      end
   end

   // The IF/ID stage has nothing above it, so it never bubbles.
   assign above = {hold[NSTAGE-2:0], 1'b0};

   assign hold_q = ppEN ? hold : {NSTAGE{1'b1}};

   for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
      // Priority: freeze, kill, hold, bubble, load.
      assign ctl[i] = !ppEN    ? HOLD   :
                      kill[i]  ? KILL   :
                      hold[i]  ? HOLD   :
                      above[i] ? BUBBLE : LOAD;

      assign bub[i]     = (stage_ctl_t'(ctl[i]) == BUBBLE);
      assign vld_nxt[i] = (stage_ctl_t'(ctl[i]) == LOAD) ? stage_vld_d[i] :
                          (stage_ctl_t'(ctl[i]) == HOLD) ? stage_vld_q[i] : 1'b0;

      ppl_stage #(
         .WIDTH   (WIDTH),
         .NOP_VAL (NOP_VAL)
      ) u_stage (
         .CLK   (CLK),
         .nRST  (nRST),
         .ctl   (ctl[i]),
         .d     (stage_d[i*WIDTH +: WIDTH]),
         .vld_d (stage_vld_d[i]),
         .q     (stage_q[i*WIDTH +: WIDTH]),
         .vld_q (stage_vld_q[i])
      );
   end

   // Popcount of the next-state valid vector so occupancy lands with the valids.
   always_comb begin
      occ_nxt = '0;
      for (int i = 0; i < NSTAGE; i++) begin
         occ_nxt = occ_nxt + OW'(vld_nxt[i]);
      end
   end

   // Occupancy register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         occupancy <= '0;
      end else begin
         occupancy <= occ_nxt;
      end
   end

`ifdef PPL_PERF_EN
   // Saturating event counters: edges with any bubble, and enabled edges with any stall request.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         bubble_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if ((|bub) && (bubble_cnt != 32'hFFFF_FFFF)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
         end
         if (ppEN && (|stall) && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end
`else
   logic unused_bub;
   assign unused_bub = |bub;
`endif

endmodule

// File: tb/tb_ppl_stage_chain.sv
// Self-checking bench for ppl_stage_chain against a rule-level reference model.
// Latency: model advances one step per clock edge; outputs sampled 1 time unit after the edge.
// Backpressure: stimulus covers stall cascade, kill, freeze and async reset; PPL_PERF_EN adds counter checks.
module tb_ppl_stage_chain;

   localparam int NSTAGE = 4;
   localparam int WIDTH  = 96;
   localparam int OW     = $clog2(NSTAGE+1);

   logic                     CLK;
   logic                     nRST;
   logic                     ppEN;
   logic [NSTAGE*WIDTH-1:0]  stage_d;
   logic [NSTAGE-1:0]        stage_vld_d;
   logic [NSTAGE-1:0]        stall;
   logic [NSTAGE-1:0]        kill;
   logic [NSTAGE*WIDTH-1:0]  stage_q;
   logic [NSTAGE-1:0]        stage_vld_q;
   logic [NSTAGE-1:0]        hold_q;
   logic [OW-1:0]            occupancy;
`ifdef PPL_PERF_EN
   logic [31:0]              bubble_cnt;
   logic [31:0]              stall_cnt;
`endif

   ppl_stage_chain #(.NSTAGE(NSTAGE), .WIDTH(WIDTH)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .ppEN        (ppEN),
      .stage_d     (stage_d),
      .stage_vld_d (stage_vld_d),
      .stall       (stall),
      .kill        (kill),
      .stage_q     (stage_q),
      .stage_vld_q (stage_vld_q),
      .hold_q      (hold_q),
      .occupancy   (occupancy)
`ifdef PPL_PERF_EN
      ,
      .bubble_cnt  (bubble_cnt),
      .stall_cnt   (stall_cnt)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Reference model: contents of each stage as plain arrays.
   logic [WIDTH-1:0] m_q [NSTAGE];
   logic [NSTAGE-1:0] m_v;

   function automatic logic [NSTAGE*WIDTH-1:0] m_flat();
      logic [NSTAGE*WIDTH-1:0] f;
      for (int i = 0; i < NSTAGE; i++) f[i*WIDTH +: WIDTH] = m_q[i];
      return f;
   endfunction

   function automatic int m_occ();
      int n = 0;
      for (int i = 0; i < NSTAGE; i++) if (m_v[i]) n++;
      return n;
   endfunction

   // A stage is held when any stall request exists at or beyond it.
   function automatic logic [NSTAGE-1:0] exp_hold(input logic en, input logic [NSTAGE-1:0] st);
      logic [NSTAGE-1:0] h;
      if (!en) return '1;
      for (int i = 0; i < NSTAGE; i++) h[i] = ((st >> i) != 0);
      return h;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NSTAGE; i++) m_q[i] = '0;
      m_v = '0;
   endtask

   task automatic set_d(input int i, input logic [WIDTH-1:0] v);
      stage_d[i*WIDTH +: WIDTH] = v;
   endtask

   task automatic rand_d();
      for (int i = 0; i < NSTAGE; i++) set_d(i, {$urandom, $urandom, $urandom});
      stage_vld_d = NSTAGE'($urandom);
   endtask

   // Clock one edge and advance the model from the inputs present at the edge.
   task automatic step();
      logic [WIDTH-1:0] nq [NSTAGE];
      logic [NSTAGE-1:0] nv;
      logic held, drained;
      for (int i = 0; i < NSTAGE; i++) begin
         nq[i] = m_q[i];
         nv[i] = m_v[i];
         if (ppEN) begin
            held    = ((stall >> i) != 0);
            drained = (i > 0) && ((stall >> (i-1)) != 0);
            if (kill[i] || (!held && drained)) begin
               nq[i] = '0;
               nv[i] = 1'b0;
            end else if (!held) begin
               nq[i] = stage_d[i*WIDTH +: WIDTH];
               nv[i] = stage_vld_d[i];
            end
         end
      end
      @(posedge CLK);
      #1;
      for (int i = 0; i < NSTAGE; i++) m_q[i] = nq[i];
      m_v = nv;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (stage_q !== '0) begin errors++; $display("FAIL reset_q: got %h expected 0", stage_q); end
      checks++;
      if (stage_vld_q !== '0) begin errors++; $display("FAIL reset_vld: got %b expected 0", stage_vld_q); end
      checks++;
      if (occupancy !== '0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
      do_reset();
   endtask

   task automatic test_stream();
      stage_vld_d = '1;
      for (int e = 0; e < 4; e++) begin
         for (int i = 0; i < NSTAGE; i++) set_d(i, WIDTH'(((e * NSTAGE) + i + 1) * 'h11));
         step();
         checks++;
         if (stage_q !== m_flat()) begin errors++; $display("FAIL stream_q[%0d]: got %h expected %h", e, stage_q, m_flat()); end
         checks++;
         if (stage_vld_q !== m_v) begin errors++; $display("FAIL stream_vld[%0d]: got %b expected %b", e, stage_vld_q, m_v); end
      end
      checks++;
      if (occupancy !== OW'(4)) begin errors++; $display("FAIL stream_occ: got %0d expected 4", occupancy); end
   endtask

   task automatic test_load_use();
      stall = 4'b0010;
      for (int i = 0; i < NSTAGE; i++) set_d(i, WIDTH'('hA0 + i));
      stage_vld_d = '1;
      #1;
      checks++;
      if (hold_q !== 4'b0011) begin errors++; $display("FAIL loaduse_hold: got %b expected 0011", hold_q); end
      step();
      checks++;
      if (stage_q !== m_flat()) begin errors++; $display("FAIL loaduse_q: got %h expected %h", stage_q, m_flat()); end
      checks++;
      if (stage_vld_q !== 4'b1011) begin errors++; $display("FAIL loaduse_vld: got %b expected 1011", stage_vld_q); end
      checks++;
      if (stage_q[3*WIDTH +: WIDTH] !== WIDTH'('hA3)) begin errors++; $display("FAIL loaduse_s3: got %h expected a3", stage_q[3*WIDTH +: WIDTH]); end
      checks++;
      if (occupancy !== OW'(3)) begin errors++; $display("FAIL loaduse_occ: got %0d expected 3", occupancy); end
      stall = '0;
   endtask

   task automatic test_kill_stall();
      stall = 4'b0001;
      kill  = 4'b0001;
      for (int i = 0; i < NSTAGE; i++) set_d(i, WIDTH'('hB0 + i));
      stage_vld_d = '1;
      step();
      checks++;
      if (stage_vld_q[0] !== 1'b0 || stage_q[0 +: WIDTH] !== '0) begin
         errors++; $display("FAIL killstall_s0: got vld %b q %h expected vld 0 q 0", stage_vld_q[0], stage_q[0 +: WIDTH]);
      end
      checks++;
      if (stage_q !== m_flat() || stage_vld_q !== m_v) begin
         errors++; $display("FAIL killstall_all: got %h/%b expected %h/%b", stage_q, stage_vld_q, m_flat(), m_v);
      end
      checks++;
      if (stage_q[3*WIDTH +: WIDTH] !== WIDTH'('hB3)) begin errors++; $display("FAIL killstall_s3: got %h expected b3", stage_q[3*WIDTH +: WIDTH]); end
      stall = '0;
      kill  = '0;
   endtask

   task automatic test_freeze();
      ppEN = 1'b0;
      kill = '1;
      for (int c = 0; c < 3; c++) begin
         rand_d();
         stall = NSTAGE'($urandom);
         #1;
         checks++;
         if (hold_q !== 4'b1111) begin errors++; $display("FAIL freeze_hold[%0d]: got %b expected 1111", c, hold_q); end
         step();
         checks++;
         if (stage_q !== m_flat() || stage_vld_q !== m_v) begin
            errors++; $display("FAIL freeze_q[%0d]: got %h/%b expected %h/%b", c, stage_q, stage_vld_q, m_flat(), m_v);
         end
      end
      ppEN  = 1'b1;
      kill  = '0;
      stall = '0;
      rand_d();
      step();
      checks++;
      if (stage_q !== m_flat() || stage_vld_q !== m_v) begin
         errors++; $display("FAIL freeze_resume: got %h/%b expected %h/%b", stage_q, stage_vld_q, m_flat(), m_v);
      end
   endtask

   task automatic test_async_reset();
      stage_vld_d = '1;
      rand_d();
      stage_vld_d = '1;
      step();
      #2;
      nRST = 1'b0;
      #1;
      model_reset();
      checks++;
      if (stage_q !== '0 || stage_vld_q !== '0) begin errors++; $display("FAIL areset_q: got %h/%b expected 0/0", stage_q, stage_vld_q); end
      checks++;
      if (occupancy !== '0) begin errors++; $display("FAIL areset_occ: got %0d expected 0", occupancy); end
      #2;
      nRST = 1'b1;
      rand_d();
      step();
      checks++;
      if (stage_q !== m_flat() || stage_vld_q !== m_v || occupancy !== OW'(m_occ())) begin
         errors++; $display("FAIL areset_resume: got %h/%b/%0d expected %h/%b/%0d", stage_q, stage_vld_q, occupancy, m_flat(), m_v, m_occ());
      end
   endtask

   task automatic test_random();
      logic [NSTAGE-1:0] eh;
      for (int c = 0; c < 300; c++) begin
         rand_d();
         ppEN = ($urandom_range(0, 7) != 0);
         for (int i = 0; i < NSTAGE; i++) begin
            stall[i] = ($urandom_range(0, 5) == 0);
            kill[i]  = ($urandom_range(0, 7) == 0);
         end
         #1;
         eh = exp_hold(ppEN, stall);
         checks++;
         if (hold_q !== eh) begin errors++; $display("FAIL rand_hold[%0d]: got %b expected %b", c, hold_q, eh); end
         step();
         checks++;
         if (stage_q !== m_flat() || stage_vld_q !== m_v) begin
            errors++; $display("FAIL rand_q[%0d]: got %h/%b expected %h/%b", c, stage_q, stage_vld_q, m_flat(), m_v);
         end
         checks++;
         if (occupancy !== OW'(m_occ())) begin errors++; $display("FAIL rand_occ[%0d]: got %0d expected %0d", c, occupancy, m_occ()); end
      end
      ppEN  = 1'b1;
      stall = '0;
      kill  = '0;
   endtask

`ifdef PPL_PERF_EN
   task automatic test_perf();
      do_reset();
      checks++;
      if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin errors++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", stall_cnt, bubble_cnt); end
      stall = 4'b0100;
      for (int c = 0; c < 5; c++) begin
         rand_d();
         step();
      end
      checks++;
      if (stall_cnt !== 32'd5) begin errors++; $display("FAIL perf_stall: got %0d expected 5", stall_cnt); end
      checks++;
      if (bubble_cnt !== 32'd5) begin errors++; $display("FAIL perf_bubble: got %0d expected 5", bubble_cnt); end
      stall = '0;
   endtask
`endif

   initial begin
      nRST        = 1'b0;
      ppEN        = 1'b1;
      stage_d     = '0;
      stage_vld_d = '0;
      stall       = '0;
      kill        = '0;
      model_reset();
      test_reset();
      test_stream();
      test_load_use();
      test_kill_stall();
      test_freeze();
      test_async_reset();
      test_random();
`ifdef PPL_PERF_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
